// File: rtl/pre_fft_sequencer.sv
// Pre-FFT chain controller: fetches an utterance from audio memory, streams it
// into the abs/moving-average/clipper chain, launches the framer over the
// clipped word range and reports done/error.
// Optional build macro PRE_FFT_SEQ_ABORT_EN adds the iabort input.
module pre_fft_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic [ADDR_W-1:0] ibase_addr,
    input  logic [ADDR_W-1:0] inum_samples,
    output logic              omem_req,
    output logic [ADDR_W-1:0] omem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              opipe_valid,
    output logic [DATA_W-1:0] opipe_data,
    output logic [ADDR_W-1:0] opipe_idx,
    input  logic              iclip_valid,
    input  logic [ADDR_W-1:0] iclip_start,
    input  logic [ADDR_W-1:0] iclip_end,
`ifdef PRE_FFT_SEQ_ABORT_EN
    input  logic              iabort,
`endif
    output logic              oframe_start,
    output logic [ADDR_W-1:0] oframe_start_addr,
    output logic [ADDR_W-1:0] oframe_end_addr,
    input  logic              iframe_done,
    output logic              obusy,
    output logic              odone,
    output logic              oerror
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_CLIP, FRAME, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, num_q, num_d, cnt_q, cnt_d;
    logic              gap_q, gap_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              clipSet_q, clipSet_d;
    logic [ADDR_W-1:0] clipStart_q, clipStart_d, clipEnd_q, clipEnd_d;
    logic              pipeValid_q, pipeValid_d;
    logic [DATA_W-1:0] pipeData_q, pipeData_d;
    logic [ADDR_W-1:0] pipeIdx_q, pipeIdx_d;
    logic              frameStart_q, frameStart_d;
    logic [ADDR_W-1:0] frameStartAddr_q, frameStartAddr_d;
    logic [ADDR_W-1:0] frameEndAddr_q, frameEndAddr_d;
    logic              error_q, error_d;

    logic              abort;
    logic              ackAccept;
    logic [ADDR_W-1:0] memAddr;
    logic [ADDR_W-1:0] effStart, effEnd;
    logic [ADDR_W:0]   rangeLimit;
    logic              clipOk;

`ifdef PRE_FFT_SEQ_ABORT_EN
    assign abort = iabort && (state_q != IDLE) && (state_q != DONE);
`else
    assign abort = 1'b0;
`endif

    // Memory side: one request at a time, dropped for the cycle after each ack
    assign memAddr   = base_q + cnt_q;
    assign omem_req  = (state_q == FETCH) && !gap_q && (cnt_q != num_q) && !abort;
    assign omem_addr = omem_req ? memAddr : '0;
    assign ackAccept = imem_ack && omem_req;

    // A result arriving this very cycle takes precedence over the latched one
    assign effStart   = iclip_valid ? iclip_start : clipStart_q;
    assign effEnd     = iclip_valid ? iclip_end   : clipEnd_q;
    assign rangeLimit = {1'b0, base_q} + {1'b0, num_q} - {{ADDR_W{1'b0}}, 1'b1};
    assign clipOk     = (effStart <= effEnd) && (effStart >= base_q) &&
                        ({1'b0, effEnd} <= rangeLimit);

    assign opipe_valid       = pipeValid_q;
    assign opipe_data        = pipeData_q;
    assign opipe_idx         = pipeIdx_q;
    assign oframe_start      = frameStart_q;
    assign oframe_start_addr = frameStartAddr_q;
    assign oframe_end_addr   = frameEndAddr_q;
    assign obusy             = (state_q != IDLE);
    assign odone             = (state_q == DONE);
    assign oerror            = error_q;

    // Next-state logic for the sequencing FSM and all of its datapath registers
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        num_d            = num_q;
        cnt_d            = cnt_q;
        gap_d            = 1'b0;
        tcnt_d           = '0;
        clipSet_d        = clipSet_q;
        clipStart_d      = clipStart_q;
        clipEnd_d        = clipEnd_q;
        pipeValid_d      = 1'b0;
        pipeData_d       = pipeData_q;
        pipeIdx_d        = pipeIdx_q;
        frameStart_d     = 1'b0;
        frameStartAddr_d = frameStartAddr_q;
        frameEndAddr_d   = frameEndAddr_q;
        error_d          = error_q;

        if (((state_q == FETCH) || (state_q == WAIT_CLIP)) && iclip_valid) begin
            clipSet_d   = 1'b1;
            clipStart_d = iclip_start;
            clipEnd_d   = iclip_end;
        end

        case (state_q)
            IDLE: begin
                if (istart) begin
                    base_d      = ibase_addr;
                    num_d       = inum_samples;
                    cnt_d       = '0;
                    clipSet_d   = 1'b0;
                    clipStart_d = '0;
                    clipEnd_d   = '0;
                    error_d     = 1'b0;
                    if (inum_samples == '0) begin
                        state_d = DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (ackAccept) begin
                    pipeValid_d = 1'b1;
                    pipeData_d  = imem_data;
                    pipeIdx_d   = memAddr;
                    cnt_d       = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    gap_d       = 1'b1;
                end else if (cnt_q == num_q) begin
                    state_d = WAIT_CLIP;
                end
            end
            WAIT_CLIP: begin
                tcnt_d = tcnt_q + {{(TW-1){1'b0}}, 1'b1};
                if (clipSet_q || iclip_valid) begin
                    if (clipOk) begin
                        state_d          = FRAME;
                        frameStart_d     = 1'b1;
                        frameStartAddr_d = effStart;
                        frameEndAddr_d   = effEnd;
                    end else begin
                        state_d = DONE;
                        error_d = 1'b1;
                    end
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
            end
            FRAME: begin
                if (iframe_done && !frameStart_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d      = DONE;
            error_d      = 1'b1;
            frameStart_d = 1'b0;
            pipeValid_d  = 1'b0;
        end

        if (state_d == DONE) begin
            frameStartAddr_d = '0;
            frameEndAddr_d   = '0;
        end
    end

    // State and datapath registers; reset aborts everything immediately
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q          <= IDLE;
            base_q           <= '0;
            num_q            <= '0;
            cnt_q            <= '0;
            gap_q            <= 1'b0;
            tcnt_q           <= '0;
            clipSet_q        <= 1'b0;
            clipStart_q      <= '0;
            clipEnd_q        <= '0;
            pipeValid_q      <= 1'b0;
            pipeData_q       <= '0;
            pipeIdx_q        <= '0;
            frameStart_q     <= 1'b0;
            frameStartAddr_q <= '0;
            frameEndAddr_q   <= '0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            num_q            <= num_d;
            cnt_q            <= cnt_d;
            gap_q            <= gap_d;
            tcnt_q           <= tcnt_d;
            clipSet_q        <= clipSet_d;
            clipStart_q      <= clipStart_d;
            clipEnd_q        <= clipEnd_d;
            pipeValid_q      <= pipeValid_d;
            pipeData_q       <= pipeData_d;
            pipeIdx_q        <= pipeIdx_d;
            frameStart_q     <= frameStart_d;
            frameStartAddr_q <= frameStartAddr_d;
            frameEndAddr_q   <= frameEndAddr_d;
            error_q          <= error_d;
        end
    end

endmodule
